// File: rtl/seg_scan_ctrl_if.sv
// Frame-load handshake and display-side signals of seg_scan_ctrl.
// The writer side uses modport master, the scan controller uses modport slave.
interface seg_scan_ctrl_if #(
   parameter int unsigned N = 4
) ();

   logic             load_valid;
   logic [4*N-1:0]   load_data;
   logic             load_ready;
   logic [N-1:0]     blank_mask;
   logic [3:0]       hex_out;
   logic [N-1:0]     anodes;
   logic             frame_start;

   modport master (
      output load_valid,
      output load_data,
      output blank_mask,
      input  load_ready,
      input  hex_out,
      input  anodes,
      input  frame_start
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  blank_mask,
      output load_ready,
      output hex_out,
      output anodes,
      output frame_start
   );

endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with GUARD/DRIVE dead time and tear-free frame loads.
// Define SEG_LZ_BLANK_EN to add leading-zero blanking on the display register.
module seg_scan_ctrl #(
   parameter int unsigned N          = 4,
   parameter int unsigned F_CLK      = 100000000,
   parameter int unsigned REFRESH_HZ = 60
) (
   input logic           clock,
   input logic           reset,
   seg_scan_ctrl_if.slave bus
);

   localparam int unsigned DIV = F_CLK / (N * REFRESH_HZ);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned DW  = (N > 1) ? $clog2(N) : 1;

   localparam logic GUARD = 1'b0;
   localparam logic DRIVE = 1'b1;

   if (DIV < 4) begin : gDivTooSmall
      $error("seg_scan_ctrl: F_CLK/(N*REFRESH_HZ) must be at least 4");
   end
   if (N < 1 || N > 8) begin : gBadN
      $error("seg_scan_ctrl: N must be in 1..8");
   end

   logic            runQ;
   logic            stateQ, stateD;
   logic [CW-1:0]   slotQ, slotD;
   logic [DW-1:0]   digitQ, digitD;
   logic [4*N-1:0]  displayQ, shadowQ;
   logic            pendingQ, pendingD;
   logic            readyQ;
   logic            frameStartQ;
   logic [3:0]      hexQ;
   logic [N-1:0]    anodesQ;

   logic            slotLast, digitLast, frameEnter, toDrive, toGuard, accept;
   logic [N-1:0]    digitOneHot;
   logic [3:0]      curNibble;
   logic            suppress;

   assign slotLast    = (slotQ == CW'(DIV - 1));
   assign digitLast   = (digitQ == DW'(N - 1));
   // The idle cycle right after reset counts as the end of a frame, so the first
   // edge out of reset opens frame 0.
   assign frameEnter  = !runQ || (slotLast && digitLast);
   assign toDrive     = (stateQ == GUARD) && (stateD == DRIVE);
   assign toGuard     = (stateQ == DRIVE) && (stateD == GUARD);
   assign accept      = bus.load_valid && readyQ;
   assign digitOneHot = N'(1) << digitQ;

   always_comb begin
      curNibble = 4'h0;
      for (int i = 0; i < int'(N); i++) begin
         if (digitQ == DW'(i)) curNibble = displayQ[4*i +: 4];
      end
   end

`ifdef SEG_LZ_BLANK_EN
   logic [N-1:0] lzMask;

   // A digit is a leading zero when it and every more-significant nibble are 0.
   always_comb begin
      logic tailZero;
      lzMask   = '0;
      tailZero = 1'b1;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         tailZero = tailZero & (displayQ[4*i +: 4] == 4'h0);
         if (i != 0) lzMask[i] = tailZero;
      end
   end

   assign suppress = |((bus.blank_mask | lzMask) & digitOneHot);
`else
   assign suppress = |(bus.blank_mask & digitOneHot);
`endif

   always_comb begin
      slotD  = slotQ;
      digitD = digitQ;
      stateD = stateQ;
      if (runQ) begin
         slotD = slotLast ? '0 : slotQ + CW'(1);
         if (slotLast) digitD = digitLast ? '0 : digitQ + DW'(1);
      end
      case (stateQ)
         GUARD:   if (runQ && slotQ == CW'(1)) stateD = DRIVE;
         DRIVE:   if (slotLast) stateD = GUARD;
         default: stateD = GUARD;
      endcase
   end

   always_comb begin
      pendingD = pendingQ;
      if (accept) pendingD = 1'b1;
      else if (frameEnter) pendingD = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         runQ        <= 1'b0;
         stateQ      <= GUARD;
         slotQ       <= '0;
         digitQ      <= '0;
         displayQ    <= '0;
         shadowQ     <= '0;
         pendingQ    <= 1'b0;
         readyQ      <= 1'b0;
         frameStartQ <= 1'b0;
         hexQ        <= 4'h0;
         anodesQ     <= '1;
      end else begin
         runQ        <= 1'b1;
         stateQ      <= stateD;
         slotQ       <= slotD;
         digitQ      <= digitD;
         pendingQ    <= pendingD;
         readyQ      <= !pendingD;
         frameStartQ <= frameEnter;
         if (accept) shadowQ <= bus.load_data;
         // accept never coincides with a transfer: readyQ is low while pending.
         if (frameEnter && pendingQ) displayQ <= shadowQ;
         if (toDrive) begin
            hexQ    <= curNibble;
            anodesQ <= suppress ? '1 : ~digitOneHot;
         end else if (toGuard) begin
            anodesQ <= '1;
         end
      end
   end

   assign bus.load_ready  = readyQ;
   assign bus.hex_out     = hexQ;
   assign bus.anodes      = anodesQ;
   assign bus.frame_start = frameStartQ;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl at N=4, DIV=10.
// Cycle k is sampled 1 time unit after the k-th rising edge following reset release.
module tb_seg_scan_ctrl;

   localparam int N = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   nCmp  = 0;
   int   nErr  = 0;

   seg_scan_ctrl_if #(.N(N)) bus ();

   seg_scan_ctrl #(
      .N(N),
      .F_CLK(2400),
      .REFRESH_HZ(60)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int k);
      while (cyc < k) tick();
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic load_frame(input logic [15:0] data);
      bus.load_data  = data;
      bus.load_valid = 1'b1;
      tick();
      bus.load_valid = 1'b0;
   endtask

   // Expected anodes for an unblanked scan: 2 dark guard cycles then 8 lit drive cycles.
   function automatic logic [3:0] scan_an(input int k);
      int s, d;
      logic [3:0] one;
      s = (k - 1) % 10;
      d = ((k - 1) / 10) % 4;
      one = 4'b0001;
      if (k < 1 || s < 2) return 4'b1111;
      return ~(one << d);
   endfunction

   task automatic test_reset();
      bus.load_valid = 1'b0;
      bus.load_data  = 16'h0;
      bus.blank_mask = 4'b0;
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      nCmp++;
      if (bus.anodes !== 4'b1111) begin
         nErr++; $display("FAIL reset_anodes: got %b want 1111", bus.anodes);
      end
      nCmp++;
      if (bus.hex_out !== 4'h0) begin
         nErr++; $display("FAIL reset_hex: got %h want 0", bus.hex_out);
      end
      nCmp++;
      if (bus.frame_start !== 1'b0) begin
         nErr++; $display("FAIL reset_frame_start: got %b want 0", bus.frame_start);
      end
      nCmp++;
      if (bus.load_ready !== 1'b0) begin
         nErr++; $display("FAIL reset_ready: got %b want 0", bus.load_ready);
      end
      reset = 1'b0;
      cyc = 0;
      tick();
      nCmp++;
      if (bus.load_ready !== 1'b1) begin
         nErr++; $display("FAIL first_ready: got %b want 1", bus.load_ready);
      end
      nCmp++;
      if (bus.frame_start !== 1'b1) begin
         nErr++; $display("FAIL first_frame_start: got %b want 1", bus.frame_start);
      end
   endtask

   task automatic test_scan();
      do_reset();
      for (int k = 1; k <= 80; k++) begin
         tick();
         nCmp++;
         if (bus.anodes !== scan_an(k)) begin
            nErr++;
            $display("FAIL scan_anodes c%0d: got %b want %b", k, bus.anodes, scan_an(k));
         end
         nCmp++;
         if (bus.frame_start !== ((k - 1) % 40 == 0)) begin
            nErr++;
            $display("FAIL scan_frame_start c%0d: got %b want %b", k, bus.frame_start,
                     ((k - 1) % 40 == 0));
         end
      end
   endtask

   task automatic test_frame_load();
      logic [3:0] expHex [4];
      expHex = '{4'h4, 4'h3, 4'h2, 4'h1};
      do_reset();
      run_to(5);
      load_frame(16'h1234);
      for (int k = 6; k <= 40; k++) begin
         nCmp++;
         if (bus.load_ready !== 1'b0) begin
            nErr++; $display("FAIL load_ready_low c%0d: got %b want 0", cyc, bus.load_ready);
         end
         tick();
      end
      nCmp++;
      if (bus.load_ready !== 1'b1 || bus.frame_start !== 1'b1) begin
         nErr++;
         $display("FAIL load_transfer c41: ready %b fs %b want 1 1", bus.load_ready,
                  bus.frame_start);
      end
      for (int i = 0; i < 4; i++) begin
         run_to(43 + 10 * i);
         nCmp++;
         if (bus.hex_out !== expHex[i] || bus.anodes !== scan_an(cyc)) begin
            nErr++;
            $display("FAIL load_hex digit%0d: got %h/%b want %h/%b", i, bus.hex_out,
                     bus.anodes, expHex[i], scan_an(cyc));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] expHex [4];
      expHex = '{4'hF, 4'hE, 4'hE, 4'hB};
      do_reset();
      run_to(5);
      load_frame(16'h1234);
      run_to(10);
      bus.load_data  = 16'hBEEF;
      bus.load_valid = 1'b1;
      for (int k = 10; k <= 19; k++) begin
         nCmp++;
         if (bus.load_ready !== 1'b0) begin
            nErr++; $display("FAIL bp_ready c%0d: got %b want 0", cyc, bus.load_ready);
         end
         tick();
      end
      bus.load_valid = 1'b0;
      run_to(41);
      nCmp++;
      if (bus.load_ready !== 1'b1) begin
         nErr++; $display("FAIL bp_ready_back: got %b want 1", bus.load_ready);
      end
      load_frame(16'hBEEF);
      nCmp++;
      if (bus.load_ready !== 1'b0) begin
         nErr++; $display("FAIL bp_accept: ready got %b want 0", bus.load_ready);
      end
      run_to(43);
      nCmp++;
      if (bus.hex_out !== 4'h4) begin
         nErr++; $display("FAIL bp_shadow_kept: got %h want 4", bus.hex_out);
      end
      for (int i = 0; i < 4; i++) begin
         run_to(83 + 10 * i);
         nCmp++;
         if (bus.hex_out !== expHex[i]) begin
            nErr++;
            $display("FAIL bp_hex digit%0d: got %h want %h", i, bus.hex_out, expHex[i]);
         end
      end
   endtask

   task automatic test_blank_mask();
      logic [3:0] want;
      bus.blank_mask = 4'b0100;
      do_reset();
      for (int k = 1; k <= 70; k++) begin
         tick();
         want = (k >= 21 && k <= 30) ? 4'b1111 : scan_an(k);
         nCmp++;
         if (bus.anodes !== want) begin
            nErr++; $display("FAIL blank_anodes c%0d: got %b want %b", k, bus.anodes, want);
         end
         // Clearing the mask mid-slot must not relight digit 2 before its next slot.
         if (k == 24) bus.blank_mask = 4'b0000;
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      run_to(5);
      load_frame(16'h1234);
      run_to(23);
      nCmp++;
      if (bus.anodes !== 4'b1011 || bus.load_ready !== 1'b0) begin
         nErr++;
         $display("FAIL midrst_before: anodes %b ready %b want 1011 0", bus.anodes,
                  bus.load_ready);
      end
      #2;
      reset = 1'b1;
      #1;
      nCmp++;
      if (bus.anodes !== 4'b1111 || bus.load_ready !== 1'b0) begin
         nErr++;
         $display("FAIL midrst_async: anodes %b ready %b want 1111 0", bus.anodes,
                  bus.load_ready);
      end
      @(negedge clock);
      reset = 1'b0;
      cyc = 0;
      run_to(1);
      nCmp++;
      if (bus.frame_start !== 1'b1 || bus.load_ready !== 1'b1) begin
         nErr++;
         $display("FAIL midrst_restart: fs %b ready %b want 1 1", bus.frame_start,
                  bus.load_ready);
      end
      run_to(3);
      nCmp++;
      if (bus.anodes !== 4'b1110 || bus.hex_out !== 4'h0) begin
         nErr++;
         $display("FAIL midrst_digit0: anodes %b hex %h want 1110 0", bus.anodes, bus.hex_out);
      end
      run_to(43);
      nCmp++;
      if (bus.hex_out !== 4'h0) begin
         nErr++; $display("FAIL midrst_discard: hex got %h want 0", bus.hex_out);
      end
   endtask

   task automatic test_lz();
      logic [3:0] want2, want3;
`ifdef SEG_LZ_BLANK_EN
      want2 = 4'b1111;
      want3 = 4'b1111;
`else
      want2 = 4'b1011;
      want3 = 4'b0111;
`endif
      do_reset();
      run_to(5);
      load_frame(16'h0050);
      run_to(43);
      nCmp++;
      if (bus.anodes !== 4'b1110 || bus.hex_out !== 4'h0) begin
         nErr++;
         $display("FAIL lz_digit0: anodes %b hex %h want 1110 0", bus.anodes, bus.hex_out);
      end
      run_to(53);
      nCmp++;
      if (bus.anodes !== 4'b1101 || bus.hex_out !== 4'h5) begin
         nErr++;
         $display("FAIL lz_digit1: anodes %b hex %h want 1101 5", bus.anodes, bus.hex_out);
      end
      run_to(63);
      nCmp++;
      if (bus.anodes !== want2) begin
         nErr++; $display("FAIL lz_digit2: anodes %b want %b", bus.anodes, want2);
      end
      run_to(73);
      nCmp++;
      if (bus.anodes !== want3) begin
         nErr++; $display("FAIL lz_digit3: anodes %b want %b", bus.anodes, want3);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_frame_load();
      test_backpressure();
      test_blank_mask();
      test_mid_reset();
      test_lz();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
